// File: rtl/prog_loader.sv
// Program loader: streams words from a ready/valid source into MEM through an
// mfc handshake, and holds the CPU in reset until a complete load has finished.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_WAIT_WORD | in_ready high, waiting for the next program word
// S_WRITE     | first cycle of the MEM write, address/data driven from latches
// S_WAIT_MFC  | write held until mfc, or until the timeout expires
// S_DONE      | load complete, CPU released; waits for reload
// S_ERROR     | timeout or overflow, CPU held in reset; waits for reload
module prog_loader #(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int unsigned MAX_WORDS   = 256,
    parameter int unsigned MFC_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reload,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data,
    output logic        mem_en,
    output logic        mem_rw,
    input  logic        mfc,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] word_count
);

    localparam logic [15:0] MAX_W    = 16'(MAX_WORDS);
    localparam logic [7:0]  TMO_LAST = 8'(MFC_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_WAIT_WORD,
        S_WRITE,
        S_WAIT_MFC,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        last_q, last_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  tmo_q, tmo_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_WAIT_WORD;
            addr_q  <= 16'h0000;
            data_q  <= 16'h0000;
            last_q  <= 1'b0;
            count_q <= 16'h0000;
            tmo_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
            count_q <= count_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last_q;
        count_d = count_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_WAIT_WORD: begin
                if (in_valid) begin
                    addr_d  = BASE_ADDR + count_q;
                    data_d  = in_data;
                    last_d  = in_last;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                tmo_d   = 8'h00;
                state_d = S_WAIT_MFC;
            end
            S_WAIT_MFC: begin
                if (mfc) begin
                    count_d = count_q + 16'd1;
                    // a flagged last word wins over the overflow check
                    if (last_q)
                        state_d = S_DONE;
                    else if (count_d == MAX_W)
                        state_d = S_ERROR;
                    else
                        state_d = S_WAIT_WORD;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_DONE, S_ERROR: begin
                if (reload) begin
                    count_d = 16'h0000;
                    tmo_d   = 8'h00;
                    state_d = S_WAIT_WORD;
                end
            end
            default: state_d = S_WAIT_WORD;
        endcase
    end

    // every output is a state decode or a flop, so in_valid/mfc never reach them combinationally
    assign in_ready   = (state_q == S_WAIT_WORD);
    assign mem_en     = (state_q == S_WRITE) || (state_q == S_WAIT_MFC);
    assign mem_rw     = mem_en;
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;
    assign cpu_reset  = (state_q != S_DONE);
    assign load_done  = (state_q == S_DONE);
    assign load_err   = (state_q == S_ERROR);
    assign word_count = count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed-plus-random bench for prog_loader with a wrapping base address and a
// small word limit; expected values come from a word-index model of the load.
module tb_prog_loader;

    localparam logic [15:0] BASE = 16'hFFFE;
    localparam int          MAXW = 4;
    localparam int          TMO  = 15;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        reload;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_en;
    logic        mem_rw;
    logic        mfc;
    logic        cpu_reset;
    logic        load_done;
    logic        load_err;
    logic [15:0] word_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_count;

    prog_loader #(
        .BASE_ADDR   (BASE),
        .MAX_WORDS   (MAXW),
        .MFC_TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .reload     (reload),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_en     (mem_en),
        .mem_rw     (mem_rw),
        .mfc        (mfc),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, expv);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %04h expected %04h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] addr_of(input int idx);
        return 16'((int'(BASE) + idx) % 65536);
    endfunction

    task automatic expect_status(input string tag, input int st);
        check1({tag, "_done"}, load_done, st == ST_DONE);
        check1({tag, "_err"}, load_err, st == ST_ERR);
        check1({tag, "_cpu_reset"}, cpu_reset, st != ST_DONE);
        check1({tag, "_ready"}, in_ready, st == ST_BUSY);
        check1({tag, "_mem_en"}, mem_en, 1'b0);
        check16({tag, "_count"}, word_count, 16'(exp_count));
    endtask

    // Present a word and follow it through acceptance; returns at the WRITE-cycle negedge
    // with a junk word already waiting on the source so a second latch would be visible.
    task automatic offer(input logic [15:0] d, input logic last);
        int k;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        k = 0;
        while (!in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        check1("offer_ready", in_ready, 1'b1);
        @(negedge clk);
        in_data = 16'($urandom);
        in_last = 1'($urandom);
        check1("write_en", mem_en, 1'b1);
        check1("write_rw", mem_rw, 1'b1);
        check16("write_addr", mem_addr, addr_of(exp_count));
        check16("write_data", mem_data, d);
        check1("write_ready", in_ready, 1'b0);
        check1("write_cpu_reset", cpu_reset, 1'b1);
    endtask

    // dly = WAIT_MFC cycles before mfc; dly >= TMO means mfc never arrives.
    task automatic complete(input int dly, input logic spurious, input logic [15:0] d,
                            input logic last);
        mfc = spurious;
        @(negedge clk);
        mfc = 1'b0;
        check16("write_mfc_ignored", word_count, 16'(exp_count));
        for (int j = 0; j < TMO; j++) begin
            check1("hold_en", mem_en, 1'b1);
            check16("hold_addr", mem_addr, addr_of(exp_count));
            check16("hold_data", mem_data, d);
            check1("hold_ready", in_ready, 1'b0);
            if (j == dly) begin
                mfc      = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                mfc = 1'b0;
                exp_count++;
                if (last)
                    expect_status("after_mfc", ST_DONE);
                else if (exp_count == MAXW)
                    expect_status("after_mfc", ST_ERR);
                else
                    expect_status("after_mfc", ST_BUSY);
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        expect_status("timeout", ST_ERR);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        exp_count = 0;
        expect_status("reload", ST_BUSY);
    endtask

    initial begin
        logic [15:0] d;
        int          n;
        reset    = 1'b0;
        reload   = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        in_last  = 1'b0;
        mfc      = 1'b0;
        exp_count = 0;

        @(negedge clk);
        expect_status("rst", ST_BUSY);
        check1("rst_rw", mem_rw, 1'b0);
        check16("rst_addr", mem_addr, 16'h0000);
        check16("rst_data", mem_data, 16'h0000);
        reset = 1'b1;
        @(negedge clk);

        // three-word load, mfc two cycles after mem_en, addresses wrap past FFFF
        offer(16'h1111, 1'b0); complete(1, 1'b0, 16'h1111, 1'b0);
        offer(16'h2222, 1'b0); complete(1, 1'b0, 16'h2222, 1'b0);
        offer(16'h3333, 1'b1); complete(1, 1'b0, 16'h3333, 1'b1);
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            expect_status("done_hold", ST_DONE);
        end
        in_valid = 1'b0;

        // reload from DONE, then a one-word program
        pulse_reload();
        offer(16'hABCD, 1'b1);
        complete(int'($urandom_range(0, 3)), 1'b1, 16'hABCD, 1'b1);

        // reload in WAIT_WORD must be ignored
        pulse_reload();
        d = 16'($urandom);
        offer(d, 1'b0); complete(0, 1'b0, d, 1'b0);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        expect_status("reload_ignored", ST_BUSY);
        d = 16'($urandom);
        offer(d, 1'b1); complete(2, 1'b0, d, 1'b1);

        // randomized loads, last word always flagged
        repeat (6) begin
            pulse_reload();
            n = int'($urandom_range(1, MAXW));
            for (int i = 0; i < n; i++) begin
                d = 16'($urandom);
                offer(d, i == n - 1);
                complete(int'($urandom_range(0, TMO - 1)), 1'($urandom), d, i == n - 1);
            end
        end

        // overflow: MAXW words without last, the next word is refused
        pulse_reload();
        for (int i = 0; i < MAXW; i++) begin
            d = 16'($urandom);
            offer(d, 1'b0);
            complete(int'($urandom_range(0, 4)), 1'b0, d, 1'b0);
        end
        in_valid = 1'b1;
        in_data  = 16'h5555;
        repeat (4) begin
            @(negedge clk);
            expect_status("overflow_hold", ST_ERR);
        end
        in_valid = 1'b0;

        // mfc on the last permitted WAIT_MFC cycle still completes
        pulse_reload();
        d = 16'($urandom);
        offer(d, 1'b1); complete(TMO - 1, 1'b0, d, 1'b1);

        // mfc never arrives
        pulse_reload();
        d = 16'($urandom);
        offer(d, 1'b0); complete(TMO + 5, 1'b0, d, 1'b0);

        // async reset during WAIT_MFC drops the write and uncounts it
        pulse_reload();
        d = 16'($urandom);
        offer(d, 1'b0); complete(0, 1'b0, d, 1'b0);
        d = 16'($urandom);
        offer(d, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        exp_count = 0;
        in_valid  = 1'b0;
        expect_status("mid_rst", ST_BUSY);
        check16("mid_rst_addr", mem_addr, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        d = 16'($urandom);
        offer(d, 1'b1); complete(1, 1'b0, d, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0000, first memory address written.
REQ-002 Parameter MAX_WORDS, default 256, maximum words per load; legal range 1..65535.
REQ-003 Parameter MFC_TIMEOUT, default 15, max cycles waited for mfc per word; legal range 1..255.
REQ-004 clk  input  1  rising-edge clock, the only clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 reload  input  1  single-cycle pulse; restarts a load from DONE or ERROR.
REQ-007 in_valid  input  1  source has a program word on in_data.
REQ-008 in_data  input  16  program word.
REQ-009 in_last  input  1  qualifies in_data as the final word; sampled with in_valid.
REQ-010 in_ready  output  1  loader accepts a word this cycle.
REQ-011 mem_addr  output  16  address to MEM.
REQ-012 mem_data  output  16  write data to MEM.
REQ-013 mem_en  output  1  MEM enable.
REQ-014 mem_rw  output  1  1 = write, 0 = read; this block only ever drives 1 while mem_en=1.
REQ-015 mfc  input  1  memory-function-complete from MEM.
REQ-016 cpu_reset  output  1  active-high hold to the CPU fetch/decode logic.
REQ-017 load_done  output  1  load finished successfully.
REQ-018 load_err  output  1  load aborted (timeout or overflow).
REQ-019 word_count  output  16  words written in the current load.

Function
REQ-020 States: WAIT_WORD, WRITE, WAIT_MFC, DONE, ERROR; encoded in one state register.
REQ-021 WAIT_WORD: in_ready=1; in_valid=1 latches in_data, in_last and addr=BASE_ADDR+word_count; go WRITE next cycle.
REQ-022 A word transfers only when in_valid && in_ready; in_ready=0 in every other state; source holds data until accepted.
REQ-023 WRITE: mem_en=1, mem_rw=1, mem_addr/mem_data stable from latched values; go WAIT_MFC next cycle.
REQ-024 WAIT_MFC: mem_en, mem_rw, mem_addr, mem_data held; timeout counter increments each cycle.
REQ-025 mfc=1 in WAIT_MFC: word_count increments by 1 the same edge; mem_en drops next cycle.
REQ-026 After mfc: latched last=1 -> DONE; else word_count(new)==MAX_WORDS -> ERROR; else -> WAIT_WORD.
REQ-027 mfc=1 in WRITE is ignored; only WAIT_MFC completes a word.
REQ-028 Timeout counter reaching MFC_TIMEOUT without mfc -> ERROR; word_count not incremented.
REQ-029 mem_addr arithmetic is 16-bit modulo; BASE_ADDR+word_count wraps past 16'hFFFF to 16'h0000.
REQ-030 DONE: cpu_reset=0, load_done=1, load_err=0, mem_en=0; stays until reload.
REQ-031 ERROR: cpu_reset=1, load_err=1, load_done=0, mem_en=0; stays until reload.
REQ-032 reload=1 in DONE or ERROR: word_count<=0, flags cleared, cpu_reset<=1, go WAIT_WORD; ignored in all other states.
REQ-033 cpu_reset=1 in every state except DONE; the CPU never runs a partial program.
REQ-034 Outputs are registered or decoded from the state only; no combinational path from in_valid or mfc to any output.

Reset
REQ-035 reset low asynchronously forces: state WAIT_WORD, cpu_reset=1, in_ready=1, mem_en=0, mem_rw=0, mem_addr=0, mem_data=0, load_done=0, load_err=0, word_count=0, timeout counter 0.
REQ-036 reset asserted mid-write drops mem_en immediately; the partially written word is not counted.
REQ-037 Leaving reset, the first accepted word goes to BASE_ADDR.

Verification
REQ-038 3 words 16'h1111, 16'h2222, 16'h3333 (last on third), mfc 2 cycles after each mem_en -> writes to addresses 0, 1, 2, word_count=3, load_done=1, cpu_reset=0.
REQ-039 in_valid held high during WRITE/WAIT_MFC -> in_ready=0, no second latch, data accepted only on return to WAIT_WORD.
REQ-040 mfc never asserted, MFC_TIMEOUT=15 -> load_err=1 after 15 WAIT_MFC cycles, word_count=0, cpu_reset=1.
REQ-041 MAX_WORDS=4, 5 words without in_last -> ERROR after 4th mfc, word_count=4, in_ready=0 for the 5th word.
REQ-042 BASE_ADDR=16'hFFFE, 3 words -> addresses FFFE, FFFF, 0000.
REQ-043 In DONE, pulse reload, then load 1 word 16'hABCD with in_last -> cpu_reset high until new DONE, word_count=1, address BASE_ADDR.
